// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: serial wide adder sequencer, one SLICE_W-bit slice per clock, LSB slice first,
// with the registered slice carry fed back into the next slice.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one slice per edge, carry fed back between slices
// DONE  | one-cycle completion pulse; a new start is accepted here as well
module csa_seq_ctrl #(
    parameter int SLICE_W = 7,
    parameter int SLICES  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [SLICE_W*SLICES-1:0]   a,
    input  logic [SLICE_W*SLICES-1:0]   b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [SLICE_W*SLICES-1:0]   sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W     = SLICE_W * SLICES;
    localparam int CNT_W = $clog2(SLICES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_slice;

    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       res_sh;
    logic [W-1:0]       res_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic [SLICE_W:0]   slice_sum;

    assign last_slice = (cnt == CNT_W'(SLICES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // New slice result enters at the top so the LSB slice ends up at the bottom after SLICES shifts.
    always_comb begin
        slice_sum = {1'b0, a_sh[SLICE_W-1:0]} + {1'b0, b_sh[SLICE_W-1:0]}
                  + {{SLICE_W{1'b0}}, carry};
        res_nxt = res_sh >> SLICE_W;
        res_nxt[W-1 -: SLICE_W] = slice_sum[SLICE_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
            a_msb  <= a[W-1];
            b_msb  <= b[W-1];
        end else if (state == RUN) begin
            a_sh   <= a_sh >> SLICE_W;
            b_sh   <= b_sh >> SLICE_W;
            res_sh <= res_nxt;
            carry  <= slice_sum[SLICE_W];
            cnt    <= cnt + CNT_W'(1);
            if (last_slice) begin
                sum  <= res_nxt;
                cout <= slice_sum[SLICE_W];
                ovf  <= (a_msb == b_msb) && (res_nxt[W-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// tb_csa_seq_ctrl: directed bench for csa_seq_ctrl; expected results are queued at accept
// and popped when done pulses.
module tb_csa_seq_ctrl;

    localparam int SLICE_W = 7;
    localparam int SLICES  = 4;
    localparam int W       = SLICE_W * SLICES;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t         exp_q[$];
    logic [W-1:0] last_sum;
    int           n_checks;
    int           n_pass;

    csa_seq_ctrl #(.SLICE_W(SLICE_W), .SLICES(SLICES)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        exp_t       e;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        a     = ai;
        b     = bi;
        cin   = ci;
        start = 1'b1;
        exp_q.push_back(model(ai, bi, ci));
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles until done, checking the old result is held meanwhile.
    task automatic wait_done(input string tag, input int already);
        int   n;
        int   guard;
        exp_t e;
        n     = already;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) n++;
            chk({tag, "_hold"}, 32'(sum), 32'(last_sum));
            step();
            guard++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(SLICES));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.s));
            chk({tag, "_cout"}, 32'(cout), 32'(e.c));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
            last_sum = e.s;
        end
    endtask

    initial begin
        int   ndone;
        exp_t dropped;
        n_checks = 0;
        n_pass   = 0;
        last_sum = '0;
        reset    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        step();

        launch(28'hFFFFFFF, 28'h0000001, 1'b0);
        chk("ripple_busy_rise", 32'(busy), 32'd1);
        wait_done("ripple", 0);
        chk("ripple_sum_const", 32'(sum), 32'h0000000);
        step();
        chk("ripple_done_pulse", 32'(done), 32'd0);

        launch(28'h1234567, 28'h0ABCDEF, 1'b1);
        wait_done("mixed", 0);
        chk("mixed_sum_const", 32'(sum), 32'h1CF1357);
        step();

        launch(28'h7FFFFFF, 28'h0000001, 1'b0);
        wait_done("ovf", 0);
        chk("ovf_flag_const", 32'(ovf), 32'd1);
        step();

        // start during RUN must not disturb the operation in progress
        launch(28'h0F0F0F0, 28'h0101010, 1'b0);
        step();
        a     = 28'hFFFFFFF;
        b     = 28'hFFFFFFF;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignore", 2);
        chk("ignore_sum_const", 32'(sum), 32'h1010100);

        // back-to-back: accept in the DONE cycle
        launch(28'h0000001, 28'h0000002, 1'b0);
        chk("b2b_busy_rise", 32'(busy), 32'd1);
        chk("b2b_prev_held", 32'(sum), 32'h1010100);
        wait_done("b2b", 0);
        chk("b2b_sum_const", 32'(sum), 32'h0000003);
        step();
        chk("b2b_done_pulse", 32'(done), 32'd0);

        // abort in the second RUN cycle
        launch(28'h1111111, 28'h2222222, 1'b0);
        step();
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        if (exp_q.size() != 0) dropped = exp_q.pop_back();
        last_sum = '0;
        @(posedge clock);
        #1 reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            step();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_sum_after", 32'(sum), 32'd0);

        launch(28'h0000005, 28'h0000006, 1'b0);
        wait_done("post_abort", 0);
        chk("post_abort_sum_const", 32'(sum), 32'h000000B);
        step();
        chk("post_abort_idle", 32'(done | busy), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
